bus_cycle_initiator: RTL

- Active bus master for the board's 68000-style bus; drives the same active-high AS/UDS/LDS/WR/FC/ADDR signals the address decoder responds to.
- Runs one word or byte read/write, or interrupt-acknowledge, cycle per client request.
- Terminates on DTACK, AVEC or BERR, or on an internal timeout.
- Used by the debug monitor and the SRAM preload path to reach memory and I/O ports while the CPU is held off the bus.

---
 rtl/bus_pkg.sv | 43 ++++
 rtl/bus_cycle_initiator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared encodings and constants for the 68000-style bus cycle initiator.
package bus_pkg;

  // Bus-cycle FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_TERM   = 2'd3
  } bus_state_e;

  // Function code that marks an interrupt-acknowledge cycle
  localparam logic [2:0] FC_IACK      = 3'b111;
  // Autovector numbers start here; the level comes from ADDR[3:1]
  localparam logic [7:0] AUTOVEC_BASE = 8'd24;

  // {UDS,LDS} lane masks
  localparam logic [1:0] MASK_NONE  = 2'b00;
  localparam logic [1:0] MASK_LOWER = 2'b01;
  localparam logic [1:0] MASK_UPPER = 2'b10;
  localparam logic [1:0] MASK_WORD  = 2'b11;

  // Right-justify the active lane(s) of a read; byte reads are zero-extended
  function automatic logic [15:0] lane_rdata(input logic [1:0] mask, input logic [15:0] din);
    logic [15:0] r;
    r = 16'h0000;
    case (mask)
      MASK_WORD:  r = din;
      MASK_UPPER: r = {8'h00, din[15:8]};
      MASK_LOWER: r = {8'h00, din[7:0]};
      default:    r = 16'h0000;
    endcase
    return r;
  endfunction

  // Byte writes put the low byte on both lanes so either strobe sees it
  function automatic logic [15:0] lane_wdata(input logic [1:0] mask, input logic [15:0] wd);
    logic [15:0] r;
    r = (mask == MASK_WORD) ? wd : {wd[7:0], wd[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_initiator.sv
// Single-access bus master: runs one read/write/IACK cycle per client request
// with SETUP -> STROBE -> TERM phasing, DTACK/AVEC/BERR termination and a
// STROBE-phase timeout.
module bus_cycle_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 24
) (
  input  logic                  CPUCLK_IN,
  input  logic                  RUN_IN,
  input  logic                  REQ_IN,
  input  logic                  REQ_WRITE_IN,
  input  logic [1:0]            REQ_MASK_IN,
  input  logic [2:0]            REQ_FC_IN,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_IN,
  input  logic [15:0]           REQ_WDATA_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic                  AUTOVEC,
  output logic [15:0]           RDATA,
  output logic                  AS_OUT,
  output logic                  WR_OUT,
  output logic                  UDS_OUT,
  output logic                  LDS_OUT,
  output logic [2:0]            FC_OUT,
  output logic [ADDR_WIDTH-1:0] ADDR_OUT,
  output logic [15:0]           DATA_OUT,
  output logic                  DATA_OE,
  input  logic [15:0]           DATA_IN,
  input  logic                  DTACK_IN,
  input  logic                  AVEC_IN,
  input  logic                  BERR_IN
);

  // Last counter value before the forced timeout termination
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  bus_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [2:0]            fc_q,    fc_d;
  logic                  wr_q,    wr_d;
  logic [1:0]            mask_q,  mask_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           cnt_q,   cnt_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_q,   err_d;
  logic                  avec_q,  avec_d;

  logic                  avec_ok;
  logic                  unused_addr0;

  // Address bit 0 never reaches the bus
  assign unused_addr0 = REQ_ADDR_IN[0];

  // AVEC only counts as a termination during interrupt-acknowledge cycles
  assign avec_ok = AVEC_IN && (fc_q == FC_IACK);

  // State, captured request and result registers
  always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      fc_q    <= 3'b000;
      wr_q    <= 1'b0;
      mask_q  <= MASK_NONE;
      wdata_q <= 16'h0000;
      cnt_q   <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      avec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fc_q    <= fc_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      avec_q  <= avec_d;
    end
  end

  // Next-state: accept, phase sequencing, termination priority and timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fc_d    = fc_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    avec_d  = avec_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ_IN) begin
          // Results of the previous access are dropped on every accept
          rdata_d = 16'h0000;
          err_d   = 1'b0;
          avec_d  = 1'b0;
          if (REQ_MASK_IN != MASK_NONE) begin
            addr_d  = {REQ_ADDR_IN[ADDR_WIDTH-1:1], 1'b0};
            fc_d    = REQ_FC_IN;
            wr_d    = REQ_WRITE_IN;
            mask_d  = REQ_MASK_IN;
            wdata_d = lane_wdata(REQ_MASK_IN, REQ_WDATA_IN);
            state_d = ST_SETUP;
          end else begin
            // Illegal mask: report an error without touching the bus
            err_d   = 1'b1;
            state_d = ST_TERM;
          end
        end
      end

      ST_SETUP: begin
        cnt_d   = 16'h0000;
        state_d = ST_STROBE;
      end

      ST_STROBE: begin
        if (BERR_IN) begin
          err_d   = 1'b1;
          state_d = ST_TERM;
        end else if (DTACK_IN) begin
          if (!wr_q) rdata_d = lane_rdata(mask_q, DATA_IN);
          state_d = ST_TERM;
        end else if (avec_ok) begin
          rdata_d = {8'h00, AUTOVEC_BASE + {5'b00000, addr_q[3:1]}};
          avec_d  = 1'b1;
          state_d = ST_TERM;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_TERM;
        end else begin
          cnt_d = cnt_q + 16'h0001;
        end
      end

      ST_TERM: begin
        // Bus qualifiers return to 0 once IDLE is reached
        addr_d  = '0;
        fc_d    = 3'b000;
        wr_d    = 1'b0;
        mask_d  = MASK_NONE;
        wdata_d = 16'h0000;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and client outputs decoded from state and captured fields
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_TERM);
  assign ERROR    = DONE && err_q;
  assign AUTOVEC  = DONE && avec_q;
  assign RDATA    = rdata_q;
  assign AS_OUT   = (state_q == ST_STROBE);
  assign UDS_OUT  = AS_OUT && mask_q[1];
  assign LDS_OUT  = AS_OUT && mask_q[0];
  assign WR_OUT   = wr_q;
  assign FC_OUT   = fc_q;
  assign ADDR_OUT = addr_q;
  assign DATA_OUT = wdata_q;
  // Write data stays enabled through TERM as a hold cycle
  assign DATA_OE  = wr_q && ((state_q == ST_STROBE) || (state_q == ST_TERM));

endmodule
